// File: rtl/uart_tx_framer_if.sv
// Parallel-side and serial-side signals of the UART transmit framer.
// slave  : framer side (takes the word and frame options, drives the line)
// master : user side (offers words, observes line/status)
//   P_DATA     parallel word to transmit
//   DATA_VALID request to transmit P_DATA
//   PAR_EN     parity bit enable
//   PAR_TYP    0 = even parity, 1 = odd parity
//   STOP2      0 = one stop bit, 1 = two stop bits
//   TX_OUT     serial line, idle high
//   Busy       high while a frame is in progress
//   DATA_ACK   one-cycle pulse when a word is accepted
interface uart_tx_framer_if #(
    parameter int unsigned DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  DATA_VALID;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic                  STOP2;
    logic                  TX_OUT;
    logic                  Busy;
    logic                  DATA_ACK;

    modport master (
        output P_DATA, DATA_VALID, PAR_EN, PAR_TYP, STOP2,
        input  TX_OUT, Busy, DATA_ACK
    );

    modport slave (
        input  P_DATA, DATA_VALID, PAR_EN, PAR_TYP, STOP2,
        output TX_OUT, Busy, DATA_ACK
    );
endinterface

// File: rtl/uart_tx_framer.sv
// UART transmit framer. One CLK period is one bit time. A word is latched
// together with its frame options when DATA_VALID is seen in IDLE or in the
// last stop cycle, then sent as: start(0), data LSB first, optional parity,
// one or two stop bits(1). All outputs come straight from flops.
//   CLK  bit-rate clock
//   RST  asynchronous active-low reset
//   bus  uart_tx_framer_if.slave (P_DATA, DATA_VALID, PAR_EN, PAR_TYP,
//        STOP2 in; TX_OUT, Busy, DATA_ACK out)
module uart_tx_framer #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic               CLK,
    input  logic               RST,
    uart_tx_framer_if.slave    bus
);
    localparam int unsigned        CNT_W    = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0]   LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP1  = 3'd4,
        S_STOP2  = 3'd5
    } state_t;

    state_t                state;
    logic [CNT_W-1:0]      bit_cnt;
    logic [CNT_W-1:0]      next_cnt;
    logic [DATA_WIDTH-1:0] data_snap;
    logic                  par_en_snap;
    logic                  par_typ_snap;
    logic                  stop2_snap;
    logic                  tx_q;
    logic                  busy_q;
    logic                  ack_q;
    logic                  parity_bit;
    logic                  accept;

    // A word can be taken in IDLE or in whichever stop cycle ends the frame.
    always_comb begin
        accept = 1'b0;
        if (bus.DATA_VALID) begin
            accept = (state == S_IDLE) ||
                     (state == S_STOP1 && !stop2_snap) ||
                     (state == S_STOP2);
        end
    end

    always_comb begin
        next_cnt   = bit_cnt + CNT_W'(1);
        parity_bit = (^data_snap) ^ par_typ_snap;
    end

    // Acceptance is handled ahead of the state case so that IDLE and both
    // final-stop paths share one snapshot/START entry.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state        <= S_IDLE;
            bit_cnt      <= '0;
            data_snap    <= '0;
            par_en_snap  <= 1'b0;
            par_typ_snap <= 1'b0;
            stop2_snap   <= 1'b0;
            tx_q         <= 1'b1;
            busy_q       <= 1'b0;
            ack_q        <= 1'b0;
        end else if (accept) begin
            state        <= S_START;
            bit_cnt      <= '0;
            data_snap    <= bus.P_DATA;
            par_en_snap  <= bus.PAR_EN;
            par_typ_snap <= bus.PAR_TYP;
            stop2_snap   <= bus.STOP2;
            tx_q         <= 1'b0;
            busy_q       <= 1'b1;
            ack_q        <= 1'b1;
        end else begin
            ack_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    tx_q   <= 1'b1;
                    busy_q <= 1'b0;
                end
                S_START: begin
                    state   <= S_DATA;
                    bit_cnt <= '0;
                    tx_q    <= data_snap[0];
                    busy_q  <= 1'b1;
                end
                S_DATA: begin
                    busy_q <= 1'b1;
                    if (bit_cnt == LAST_BIT) begin
                        bit_cnt <= '0;
                        if (par_en_snap) begin
                            state <= S_PARITY;
                            tx_q  <= parity_bit;
                        end else begin
                            state <= S_STOP1;
                            tx_q  <= 1'b1;
                        end
                    end else begin
                        bit_cnt <= next_cnt;
                        tx_q    <= data_snap[next_cnt];
                    end
                end
                S_PARITY: begin
                    state  <= S_STOP1;
                    tx_q   <= 1'b1;
                    busy_q <= 1'b1;
                end
                S_STOP1: begin
                    if (stop2_snap) begin
                        state  <= S_STOP2;
                        tx_q   <= 1'b1;
                        busy_q <= 1'b1;
                    end else begin
                        state  <= S_IDLE;
                        tx_q   <= 1'b1;
                        busy_q <= 1'b0;
                    end
                end
                S_STOP2: begin
                    state  <= S_IDLE;
                    tx_q   <= 1'b1;
                    busy_q <= 1'b0;
                end
                default: begin
                    state   <= S_IDLE;
                    bit_cnt <= '0;
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.TX_OUT   = tx_q;
    assign bus.Busy     = busy_q;
    assign bus.DATA_ACK = ack_q;
endmodule

// File: tb/tb_uart_tx_framer.sv
// Bench for uart_tx_framer: an 8-bit and a 7-bit instance share one stimulus
// stream; a frame-queue model predicts the line, Busy and DATA_ACK for each.
module tb_uart_tx_framer;
    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       dv, pe, pt, s2;
    logic [7:0] pd;

    int nvec = 0;
    int nerr = 0;

    always #5 CLK = ~CLK;

    uart_tx_framer_if #(.DATA_WIDTH(8)) bus8 ();
    uart_tx_framer_if #(.DATA_WIDTH(7)) bus7 ();

    assign bus8.P_DATA     = pd;
    assign bus8.DATA_VALID = dv;
    assign bus8.PAR_EN     = pe;
    assign bus8.PAR_TYP    = pt;
    assign bus8.STOP2      = s2;
    assign bus7.P_DATA     = pd[6:0];
    assign bus7.DATA_VALID = dv;
    assign bus7.PAR_EN     = pe;
    assign bus7.PAR_TYP    = pt;
    assign bus7.STOP2      = s2;

    uart_tx_framer #(.DATA_WIDTH(8)) dut8 (.CLK(CLK), .RST(RST), .bus(bus8.slave));
    uart_tx_framer #(.DATA_WIDTH(7)) dut7 (.CLK(CLK), .RST(RST), .bus(bus7.slave));

    logic tx8, busy8, ack8, tx7, busy7, ack7;
    assign tx8   = bus8.TX_OUT;
    assign busy8 = bus8.Busy;
    assign ack8  = bus8.DATA_ACK;
    assign tx7   = bus7.TX_OUT;
    assign busy7 = bus7.Busy;
    assign ack7  = bus7.DATA_ACK;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Whole frame as a bit list, first bit on the line in bit 0.
    function automatic void build(input logic [7:0] d, input int w, input logic p_en,
                                  input logic p_odd, input logic two_stop,
                                  output logic [23:0] f, output int n);
        logic par;
        f   = '0;
        n   = 0;
        par = p_odd;
        f[n] = 1'b0; n++;
        for (int i = 0; i < w; i++) begin
            f[n] = d[i]; n++;
            par  = par ^ d[i];
        end
        if (p_en) begin f[n] = par; n++; end
        f[n] = 1'b1; n++;
        if (two_stop) begin f[n] = 1'b1; n++; end
    endfunction

    // Model: a word is taken only when no bits of the current frame remain.
    logic [23:0] pend8, pend7;
    int          plen8 = 0, plen7 = 0;
    logic        etx8 = 1'b1, ebusy8 = 1'b0, eack8 = 1'b0;
    logic        etx7 = 1'b1, ebusy7 = 1'b0, eack7 = 1'b0;

    always @(posedge CLK or negedge RST) begin
        if (!RST) begin
            plen8 = 0; etx8 = 1'b1; ebusy8 = 1'b0; eack8 = 1'b0;
            plen7 = 0; etx7 = 1'b1; ebusy7 = 1'b0; eack7 = 1'b0;
        end else begin
            eack8 = 1'b0;
            if (dv && plen8 == 0) begin build(pd, 8, pe, pt, s2, pend8, plen8); eack8 = 1'b1; end
            if (plen8 > 0) begin
                etx8 = pend8[0]; pend8 = pend8 >> 1; plen8--; ebusy8 = 1'b1;
            end else begin
                etx8 = 1'b1; ebusy8 = 1'b0;
            end
            eack7 = 1'b0;
            if (dv && plen7 == 0) begin build(pd, 7, pe, pt, s2, pend7, plen7); eack7 = 1'b1; end
            if (plen7 > 0) begin
                etx7 = pend7[0]; pend7 = pend7 >> 1; plen7--; ebusy7 = 1'b1;
            end else begin
                etx7 = 1'b1; ebusy7 = 1'b0;
            end
        end
    end

    always @(negedge CLK) begin
        chk("tx8",   32'(tx8),   32'(etx8));
        chk("busy8", 32'(busy8), 32'(ebusy8));
        chk("ack8",  32'(ack8),  32'(eack8));
        chk("tx7",   32'(tx7),   32'(etx7));
        chk("busy7", 32'(busy7), 32'(ebusy7));
        chk("ack7",  32'(ack7),  32'(eack7));
    end

    logic [23:0] cap8, cap7;
    int          acks8, busys8, acks7, busys7;

    // One request, then n cycles observed starting with the START cycle.
    task automatic run(input logic [7:0] d, input logic pe_i, input logic pt_i,
                       input logic s2_i, input logic [7:0] d2, input int hold,
                       input int n, input int tog, input int poke);
        @(negedge CLK);
        pd = d; pe = pe_i; pt = pt_i; s2 = s2_i; dv = 1'b1;
        cap8 = '0; cap7 = '0; acks8 = 0; busys8 = 0; acks7 = 0; busys7 = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            cap8[i] = tx8; cap7[i] = tx7;
            acks8 += int'(ack8); busys8 += int'(busy8);
            acks7 += int'(ack7); busys7 += int'(busy7);
            if (i == 0) pd = d2;
            dv = (i < hold) || (i == poke);
            if (i == tog) begin pd = ~pd; pt = ~pt; s2 = ~s2; pe = ~pe; end
        end
    endtask

    initial begin
        logic [23:0] f;
        int          n;

        dv = 1'b0; pd = '0; pe = 1'b0; pt = 1'b0; s2 = 1'b0;
        RST = 1'b0;
        #2;
        chk("rst_tx8",   32'(tx8),   32'd1);
        chk("rst_busy8", 32'(busy8), 32'd0);
        chk("rst_ack8",  32'(ack8),  32'd0);
        chk("rst_tx7",   32'(tx7),   32'd1);
        chk("rst_busy7", 32'(busy7), 32'd0);

        // Model pins.
        build(8'hA5, 8, 1'b0, 1'b0, 1'b0, f, n);
        chk("mdl_a5", 32'(f), 32'h34A); chk("mdl_a5_len", 32'(n), 32'd10);
        build(8'hA5, 8, 1'b1, 1'b1, 1'b0, f, n);
        chk("mdl_a5_odd", 32'(f), 32'h74A);
        build(8'h7F, 7, 1'b1, 1'b0, 1'b1, f, n);
        chk("mdl_7f", 32'(f), 32'h7FE); chk("mdl_7f_len", 32'(n), 32'd11);

        repeat (3) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);

        // Basic 8N1 frame.
        run(8'hA5, 1'b0, 1'b0, 1'b0, 8'hA5, 0, 12, -1, -1);
        chk("a5_seq",  32'(cap8[9:0]), 32'h34A);
        chk("a5_busy", 32'(busys8), 32'd10);
        chk("a5_ack",  32'(acks8),  32'd1);

        // Even and odd parity.
        run(8'hA5, 1'b1, 1'b0, 1'b0, 8'hA5, 0, 12, -1, -1);
        chk("even_seq",  32'(cap8[10:0]), 32'h54A);
        chk("even_busy", 32'(busys8), 32'd11);
        run(8'hA5, 1'b1, 1'b1, 1'b0, 8'hA5, 0, 12, -1, -1);
        chk("odd_seq", 32'(cap8[10:0]), 32'h74A);

        // 7-bit word, even parity, two stop bits.
        run(8'h7F, 1'b1, 1'b0, 1'b1, 8'h7F, 0, 12, -1, -1);
        chk("w7_seq",  32'(cap7[10:0]), 32'h7FE);
        chk("w7_busy", 32'(busys7), 32'd11);
        chk("w7_ack",  32'(acks7),  32'd1);

        // Back-to-back frames with DATA_VALID held high.
        run(8'h01, 1'b0, 1'b0, 1'b0, 8'h80, 10, 22, -1, -1);
        chk("b2b_seq",  32'(cap8[19:0]), 32'hC0202);
        chk("b2b_busy", 32'(busys8), 32'd20);
        chk("b2b_ack",  32'(acks8),  32'd2);

        // Inputs toggled mid-frame do not disturb the frame.
        run(8'hA5, 1'b1, 1'b0, 1'b0, 8'hA5, 0, 12, 3, -1);
        chk("tog_seq",  32'(cap8[10:0]), 32'h54A);
        chk("tog_busy", 32'(busys8), 32'd11);

        // DATA_VALID in the non-final stop cycle and in DATA is ignored.
        run(8'hA5, 1'b0, 1'b0, 1'b1, 8'hA5, 0, 13, -1, 9);
        chk("stp_seq",  32'(cap8[10:0]), 32'h74A);
        chk("stp_ack",  32'(acks8),  32'd1);
        chk("stp_busy", 32'(busys8), 32'd11);
        run(8'h3C, 1'b0, 1'b0, 1'b0, 8'h3C, 0, 12, -1, 4);
        chk("dat_seq", 32'(cap8[9:0]), 32'h278);
        chk("dat_ack", 32'(acks8), 32'd1);

        // Asynchronous reset during data bit 3.
        @(negedge CLK);
        pd = 8'hA5; pe = 1'b0; pt = 1'b0; s2 = 1'b0; dv = 1'b1;
        @(negedge CLK);
        dv = 1'b0;
        repeat (4) @(negedge CLK);
        chk("pre_rst_bit3", 32'(tx8), 32'd0);
        #2 RST = 1'b0;
        #1;
        chk("arst_tx8",   32'(tx8),   32'd1);
        chk("arst_busy8", 32'(busy8), 32'd0);
        chk("arst_ack8",  32'(ack8),  32'd0);
        repeat (2) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        run(8'h3C, 1'b0, 1'b0, 1'b0, 8'h3C, 0, 12, -1, -1);
        chk("post_rst_seq",  32'(cap8[9:0]), 32'h278);
        chk("post_rst_busy", 32'(busys8), 32'd10);
        chk("post_rst_ack",  32'(acks8),  32'd1);

        repeat (2) @(negedge CLK);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end
endmodule
